log_frame_stats: RTL and testbench

- Downstream consumer of the log lookup stage: takes its 16-bit signed log-domain pixel stream (tvalid-only, no backpressure) and gathers per-frame statistics.
- Per frame it reports min, max, signed sum, valid-pixel count and sentinel count.
- Results drive the log-domain contrast/normalisation stage and software readout.
- Frame boundaries come from a runtime frame length, because the upstream stream carries no tlast.

---
 rtl/log_frame_stats_if.sv | 34 +++
 rtl/log_frame_stats.sv | 133 +++++++++++++
 tb/tb_log_frame_stats.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/log_frame_stats_if.sv
// Bus bundle for log_frame_stats: the incoming log-domain pixel stream plus the
// published per-frame statistics and an FSM state debug tap.
interface log_frame_stats_if #(
  parameter int DATA_BITS = 16,
  parameter int CNT_BITS  = 32,
  parameter int SUM_BITS  = 48
);
  // Handshake: tvalid_in alone qualifies a beat; there is no ready, so every
  // cycle with tvalid_in high is one accepted beat. stat_valid is a one-cycle
  // pulse with the stat_* values already updated in that cycle.
  logic [CNT_BITS-1:0]  frame_len;
  logic [DATA_BITS-1:0] tdata_in;
  logic                 tvalid_in;
  logic [DATA_BITS-1:0] stat_min;
  logic [DATA_BITS-1:0] stat_max;
  logic [SUM_BITS-1:0]  stat_sum;
  logic [CNT_BITS-1:0]  stat_count;
  logic [CNT_BITS-1:0]  stat_sent_count;
  logic                 stat_valid;
  logic                 busy;
  logic [1:0]           dbg_state;

  modport master (
    output frame_len, tdata_in, tvalid_in,
    input  stat_min, stat_max, stat_sum, stat_count, stat_sent_count,
    input  stat_valid, busy, dbg_state
  );

  modport slave (
    input  frame_len, tdata_in, tvalid_in,
    output stat_min, stat_max, stat_sum, stat_count, stat_sent_count,
    output stat_valid, busy, dbg_state
  );
endinterface

// File: rtl/log_frame_stats.sv
// Per-frame min/max/sum/count/sentinel statistics over a tvalid-only log stream.
// Frames are delimited by a length sampled on each frame's first beat.
module log_frame_stats #(
  parameter int                   DATA_BITS = 16,
  parameter logic [DATA_BITS-1:0] SENTINEL  = 16'h8800,
  parameter int                   CNT_BITS  = 32,
  parameter int                   SUM_BITS  = 48
) (
  input  logic             clk,
  input  logic             rst,
  log_frame_stats_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  localparam logic [DATA_BITS-1:0] MIN_INIT = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic [DATA_BITS-1:0] MAX_INIT = {1'b1, {(DATA_BITS-1){1'b0}}};

  state_e                      state_q, state_d;
  logic [CNT_BITS-1:0]         len_q, len_d;
  logic [CNT_BITS-1:0]         beat_cnt_q, beat_cnt_d;
  logic [CNT_BITS-1:0]         cnt_q, cnt_d;
  logic [CNT_BITS-1:0]         sent_q, sent_d;
  logic signed [DATA_BITS-1:0] min_q, min_d;
  logic signed [DATA_BITS-1:0] max_q, max_d;
  logic signed [SUM_BITS-1:0]  sum_q, sum_d;

  logic [DATA_BITS-1:0]        st_min_q, st_max_q;
  logic [SUM_BITS-1:0]         st_sum_q;
  logic [CNT_BITS-1:0]         st_cnt_q, st_sent_q;

  logic                        first_beat;
  logic [CNT_BITS-1:0]         eff_len;
  logic [CNT_BITS-1:0]         b_beat, b_cnt, b_sent;
  logic signed [DATA_BITS-1:0] b_min, b_max, sample;
  logic signed [SUM_BITS-1:0]  b_sum;

  assign sample = $signed(bus.tdata_in);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    cnt_d      = cnt_q;
    sent_d     = sent_q;
    min_d      = min_q;
    max_d      = max_q;
    sum_d      = sum_q;
    eff_len    = len_q;

    // IDLE and PUBLISH both treat an arriving beat as the start of a new frame.
    first_beat = (state_q != ACCUM);
    b_beat = first_beat ? '0 : beat_cnt_q;
    b_cnt  = first_beat ? '0 : cnt_q;
    b_sent = first_beat ? '0 : sent_q;
    b_min  = first_beat ? $signed(MIN_INIT) : min_q;
    b_max  = first_beat ? $signed(MAX_INIT) : max_q;
    b_sum  = first_beat ? '0 : sum_q;

    if (bus.tvalid_in) begin
      if (first_beat) begin
        len_d   = (bus.frame_len == '0) ? CNT_BITS'(1) : bus.frame_len;
        eff_len = len_d;
      end
      beat_cnt_d = b_beat + CNT_BITS'(1);
      cnt_d      = b_cnt;
      sent_d     = b_sent;
      min_d      = b_min;
      max_d      = b_max;
      sum_d      = b_sum;
      if (bus.tdata_in == SENTINEL) begin
        sent_d = b_sent + CNT_BITS'(1);
      end else begin
        cnt_d = b_cnt + CNT_BITS'(1);
        sum_d = b_sum + {{(SUM_BITS-DATA_BITS){bus.tdata_in[DATA_BITS-1]}}, bus.tdata_in};
        if (sample < b_min) min_d = sample;
        if (sample > b_max) max_d = sample;
      end
      state_d = (beat_cnt_d == eff_len) ? PUBLISH : ACCUM;
    end else if (state_q == PUBLISH) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      cnt_q      <= '0;
      sent_q     <= '0;
      min_q      <= $signed(MIN_INIT);
      max_q      <= $signed(MAX_INIT);
      sum_q      <= '0;
      st_min_q   <= '0;
      st_max_q   <= '0;
      st_sum_q   <= '0;
      st_cnt_q   <= '0;
      st_sent_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      cnt_q      <= cnt_d;
      sent_q     <= sent_d;
      min_q      <= min_d;
      max_q      <= max_d;
      sum_q      <= sum_d;
      // Load on the closing beat so the values are visible alongside the pulse.
      if (state_d == PUBLISH) begin
        st_min_q  <= (cnt_d == '0) ? SENTINEL : min_d;
        st_max_q  <= (cnt_d == '0) ? SENTINEL : max_d;
        st_sum_q  <= sum_d;
        st_cnt_q  <= cnt_d;
        st_sent_q <= sent_d;
      end
    end
  end

  assign bus.stat_min        = st_min_q;
  assign bus.stat_max        = st_max_q;
  assign bus.stat_sum        = st_sum_q;
  assign bus.stat_count      = st_cnt_q;
  assign bus.stat_sent_count = st_sent_q;
  assign bus.stat_valid      = (state_q == PUBLISH);
  assign bus.busy            = (state_q == ACCUM) || ((state_q == PUBLISH) && bus.tvalid_in);
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_log_frame_stats.sv
// Bench for log_frame_stats: directed frames from the test plan plus randomized
// frames, checked against a frame-level reference model.
module tb_log_frame_stats;

  typedef struct packed {
    logic [15:0] mn;
    logic [15:0] mx;
    logic [47:0] sum;
    logic [31:0] cnt;
    logic [31:0] sent;
  } stat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulse_cnt = 0;
  bit   mon_en = 1'b0;

  // reference model state
  bit          in_frame = 1'b0;
  int          cur_len = 0;
  logic [15:0] fr_q[$];
  stat_t       exp_q[$];
  int          exp_cyc_q[$];
  stat_t       last_stat = '0;

  log_frame_stats_if #(.DATA_BITS(16), .CNT_BITS(32), .SUM_BITS(48)) bus ();

  log_frame_stats dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic stat_t frame_stats();
    stat_t r;
    logic signed [15:0] mn;
    logic signed [15:0] mx;
    longint s;
    int c;
    int sc;
    mn = 16'sh7fff;
    mx = -16'sh8000;
    s  = 0;
    c  = 0;
    sc = 0;
    foreach (fr_q[i]) begin
      if (fr_q[i] == 16'h8800) sc++;
      else begin
        s += longint'($signed(fr_q[i]));
        c++;
        if ($signed(fr_q[i]) < mn) mn = fr_q[i];
        if ($signed(fr_q[i]) > mx) mx = fr_q[i];
      end
    end
    if (c == 0) begin
      mn = 16'h8800;
      mx = 16'h8800;
    end
    r.mn   = mn;
    r.mx   = mx;
    r.sum  = s[47:0];
    r.cnt  = c;
    r.sent = sc;
    return r;
  endfunction

  task automatic model_beat(input logic [15:0] d, input logic [31:0] fl, input int tag);
    if (!in_frame) begin
      cur_len  = (fl == 0) ? 1 : int'(fl);
      in_frame = 1'b1;
      fr_q.delete();
    end
    fr_q.push_back(d);
    if (fr_q.size() == cur_len) begin
      exp_q.push_back(frame_stats());
      exp_cyc_q.push_back(tag);
      in_frame = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input logic [15:0] d, input logic [31:0] fl);
    @(negedge clk);
    bus.tvalid_in = 1'b1;
    bus.tdata_in  = d;
    bus.frame_len = in_frame ? $urandom : fl;
    model_beat(d, bus.frame_len, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.tvalid_in = 1'b0;
      bus.tdata_in  = 16'($urandom);
      bus.frame_len = $urandom;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.tvalid_in = 1'b0;
    in_frame = 1'b0;
    fr_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    last_stat = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    stat_t obs;
    bit want_valid;
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      want_valid = 1'b0;
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        last_stat = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        want_valid = 1'b1;
      end
      if (bus.stat_valid === 1'b1) pulse_cnt++;
      vectors++;
      if (bus.stat_valid !== want_valid) begin
        miscompares++;
        $display("FAIL stat_valid @cyc %0d: got %b want %b", cyc, bus.stat_valid, want_valid);
      end
      obs = {bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count};
      vectors++;
      if (obs !== last_stat) begin
        miscompares++;
        $display("FAIL stats @cyc %0d: got min=%h max=%h sum=%h cnt=%0d sent=%0d want min=%h max=%h sum=%h cnt=%0d sent=%0d",
                 cyc, obs.mn, obs.mx, obs.sum, obs.cnt, obs.sent,
                 last_stat.mn, last_stat.mx, last_stat.sum, last_stat.cnt, last_stat.sent);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.tvalid_in = 1'b0;
    bus.tdata_in  = '0;
    bus.frame_len = '0;
    do_reset(2);
    mon_en = 1'b1;
    vectors++;
    if ({bus.stat_valid, bus.busy, bus.dbg_state} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b state=%0d want 0 0 0", bus.stat_valid, bus.busy, bus.dbg_state);
    end
    vectors++;
    if ({bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_stats: got min=%h max=%h sum=%h want all zero", bus.stat_min, bus.stat_max, bus.stat_sum);
    end
  endtask

  task automatic test_basic();
    beat(16'h0010, 4);
    beat(16'hFFF0, 4);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy: got %b want 1", bus.busy);
    end
    beat(16'h0005, 4);
    beat(16'h0003, 4);
    idle(2);
    vectors++;
    if ({bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count} !==
        {16'hFFF0, 16'h0010, 48'h000000000008, 32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL basic_stats: got min=%h max=%h sum=%h cnt=%0d sent=%0d want FFF0 0010 8 4 0",
               bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle_busy: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_gaps();
    int p0;
    p0 = pulse_cnt;
    beat(16'h8800, 3);
    idle(2);
    beat(16'h0100, 3);
    idle(2);
    beat(16'h8800, 3);
    idle(3);
    vectors++;
    if ({bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count} !==
        {16'h0100, 16'h0100, 48'd256, 32'd1, 32'd2}) begin
      miscompares++;
      $display("FAIL gaps_stats: got min=%h max=%h sum=%h cnt=%0d sent=%0d want 0100 0100 256 1 2",
               bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count);
    end
    vectors++;
    if (pulse_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL gaps_pulses: got %0d want 1", pulse_cnt - p0);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulse_cnt;
    beat(16'd1, 2);
    beat(16'd2, 2);
    beat(16'd3, 2);
    vectors++;
    if (bus.busy !== 1'b1 || bus.stat_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_publish_busy: got busy=%b valid=%b want 1 1", bus.busy, bus.stat_valid);
    end
    beat(16'd4, 2);
    beat(16'd5, 2);
    beat(16'd6, 2);
    idle(2);
    vectors++;
    if (pulse_cnt - p0 != 3) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d want 3", pulse_cnt - p0);
    end
    vectors++;
    if (bus.stat_sum !== 48'd11 || bus.stat_count !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_last: got sum=%0d cnt=%0d want 11 2", bus.stat_sum, bus.stat_count);
    end
  endtask

  task automatic test_len_zero();
    beat(16'h7FFF, 0);
    idle(2);
    vectors++;
    if ({bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count} !==
        {16'h7FFF, 16'h7FFF, 48'h7FFF, 32'd1}) begin
      miscompares++;
      $display("FAIL len_zero: got min=%h max=%h sum=%h cnt=%0d want 7FFF 7FFF 7FFF 1",
               bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count);
    end
  endtask

  task automatic test_all_sentinel();
    beat(16'h8800, 2);
    beat(16'h8800, 2);
    idle(2);
    vectors++;
    if ({bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count} !==
        {16'h8800, 16'h8800, 48'd0, 32'd0, 32'd2}) begin
      miscompares++;
      $display("FAIL all_sentinel: got min=%h max=%h sum=%h cnt=%0d sent=%0d want 8800 8800 0 0 2",
               bus.stat_min, bus.stat_max, bus.stat_sum, bus.stat_count, bus.stat_sent_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int p0;
    p0 = pulse_cnt;
    beat(16'h0011, 5);
    beat(16'h0022, 5);
    beat(16'h0033, 5);
    do_reset(1);
    idle(1);
    vectors++;
    if ({bus.stat_sum, bus.stat_count, bus.busy} !== '0 || pulse_cnt != p0) begin
      miscompares++;
      $display("FAIL abort_reset: got sum=%h cnt=%0d busy=%b pulses=%0d want 0 0 0 0",
               bus.stat_sum, bus.stat_count, bus.busy, pulse_cnt - p0);
    end
    beat(16'h0001, 1);
    idle(2);
    vectors++;
    if (bus.stat_sum !== 48'd1 || bus.stat_count !== 32'd1 || pulse_cnt - p0 != 1) begin
      miscompares++;
      $display("FAIL abort_next: got sum=%0d cnt=%0d pulses=%0d want 1 1 1",
               bus.stat_sum, bus.stat_count, pulse_cnt - p0);
    end
  endtask

  task automatic test_random();
    int len;
    logic [15:0] d;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(0, 6);
      for (int b = 0; b < ((len == 0) ? 1 : len); b++) begin
        if ($urandom_range(0, 3) == 0) d = 16'h8800;
        else d = 16'($urandom);
        beat(d, 32'(len));
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_drain: got %0d pending frames want 0", exp_q.size());
    end
  endtask

  initial begin
    bus.tvalid_in = 1'b0;
    bus.tdata_in  = '0;
    bus.frame_len = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_len_zero();
    test_all_sentinel();
    test_reset_mid_frame();
    test_random();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
